// File: rtl/ball_motion_integrator_if.sv
// ball_motion_integrator_if
//   Bundles the frame/velocity signals between the velocity mux, the
//   per-ball motion integrator and the drawing / hit logic.
//   master : velocity source side (drives strobes and velocity, reads state)
//   slave  : ball_motion_integrator side
//   startOfFrame         one-cycle pulse per video frame
//   velocityWriteEnable  velocity load strobe
//   inVelocityX/Y        signed velocity to load (1/2^FP_BITS px per frame)
//   outVelocityX/Y       current registered velocity
//   topLeftX/Y           integer pixel position (floor of accumulator)
//   moving               ball is rolling
//   stopPulse            one-cycle pulse when the ball comes to rest
interface ball_motion_integrator_if;
   logic               startOfFrame;
   logic               velocityWriteEnable;
   logic signed [10:0] inVelocityX;
   logic signed [10:0] inVelocityY;
   logic signed [10:0] outVelocityX;
   logic signed [10:0] outVelocityY;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic               moving;
   logic               stopPulse;

   modport master (
      output startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
      input  outVelocityX, outVelocityY, topLeftX, topLeftY, moving, stopPulse
   );

   modport slave (
      input  startOfFrame, velocityWriteEnable, inVelocityX, inVelocityY,
      output outVelocityX, outVelocityY, topLeftX, topLeftY, moving, stopPulse
   );
endinterface

// File: rtl/ball_motion_integrator.sv
// ball_motion_integrator
//   Per-ball motion state. Latches (saturated) velocity on a load strobe,
//   integrates velocity into a fixed-point position once per frame, and
//   applies rolling friction every FRICTION_PERIOD frames.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : ball_motion_integrator_if.slave (strobes, velocity in/out,
//            topLeft position, moving, stopPulse)
module ball_motion_integrator #(
   parameter int FP_BITS         = 6,
   parameter int FRICTION_PERIOD = 4,
   parameter int FRICTION_STEP   = 1,
   parameter int MAX_SPEED       = 511,
   parameter int INIT_X          = 200,
   parameter int INIT_Y          = 200
) (
   input  logic                        clk,
   input  logic                        resetN,
   ball_motion_integrator_if.slave     bus
);

   localparam int ACC_W = 11 + FP_BITS;
   localparam int CW    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

   localparam logic signed [10:0]      VMAX    = 11'(MAX_SPEED);
   localparam logic signed [10:0]      VSTEP   = 11'(FRICTION_STEP);
   localparam logic [CW-1:0]           CNT_TOP = CW'(FRICTION_PERIOD - 1);
   localparam logic signed [ACC_W-1:0] INIT_PX = ACC_W'(INIT_X * (2 ** FP_BITS));
   localparam logic signed [ACC_W-1:0] INIT_PY = ACC_W'(INIT_Y * (2 ** FP_BITS));

   typedef enum logic {STOPPED, ROLLING} state_t;

   state_t                 state_q, state_d;
   logic signed [10:0]     vx_q, vy_q, vx_d, vy_d;
   logic signed [ACC_W-1:0] px_q, py_q, px_d, py_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   moving_q, moving_d;
   logic                   stop_q, stop_d;

   // Clamp to +/-MAX_SPEED; -1024 lands on -MAX_SPEED, keeping speed symmetric.
   function automatic logic signed [10:0] sat(input logic signed [10:0] v);
      if (v > VMAX)
         return VMAX;
      else if (v < -VMAX)
         return -VMAX;
      else
         return v;
   endfunction

   // Move toward zero by FRICTION_STEP without crossing it.
   function automatic logic signed [10:0] decay(input logic signed [10:0] v);
      if (v > VSTEP)
         return v - VSTEP;
      else if (v < -VSTEP)
         return v + VSTEP;
      else
         return '0;
   endfunction

   // Datapath next values. Integration always uses the velocity held before
   // this edge, so a simultaneous load only affects the following frame.
   always_comb begin
      vx_d  = vx_q;
      vy_d  = vy_q;
      px_d  = px_q;
      py_d  = py_q;
      cnt_d = cnt_q;

      if (bus.startOfFrame) begin
         px_d = px_q + ACC_W'(vx_q);
         py_d = py_q + ACC_W'(vy_q);
      end

      if (bus.velocityWriteEnable) begin
         vx_d  = sat(bus.inVelocityX);
         vy_d  = sat(bus.inVelocityY);
         cnt_d = '0;
      end else if (bus.startOfFrame) begin
         if (cnt_q == CNT_TOP) begin
            cnt_d = '0;
            vx_d  = decay(vx_q);
            vy_d  = decay(vy_q);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         state_q <= STOPPED;
      else
         state_q <= state_d;
   end

   // Next-state logic: motion is defined by the velocity being loaded next.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STOPPED: if (vx_d != '0 || vy_d != '0) state_d = ROLLING;
         ROLLING: if (vx_d == '0 && vy_d == '0) state_d = STOPPED;
         default: state_d = STOPPED;
      endcase
   end

   // Output logic (registered below so moving/stopPulse align with state_q)
   always_comb begin
      moving_d = (state_d == ROLLING);
      stop_d   = (state_q == ROLLING) && (state_d == STOPPED);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vx_q     <= '0;
         vy_q     <= '0;
         px_q     <= INIT_PX;
         py_q     <= INIT_PY;
         cnt_q    <= '0;
         moving_q <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         px_q     <= px_d;
         py_q     <= py_d;
         cnt_q    <= cnt_d;
         moving_q <= moving_d;
         stop_q   <= stop_d;
      end
   end

   assign bus.outVelocityX = vx_q;
   assign bus.outVelocityY = vy_q;
   // Arithmetic shift right by FP_BITS: the upper 11 bits floor toward -inf.
   assign bus.topLeftX     = px_q[FP_BITS +: 11];
   assign bus.topLeftY     = py_q[FP_BITS +: 11];
   assign bus.moving       = moving_q;
   assign bus.stopPulse    = stop_q;

endmodule

// File: tb/tb_ball_motion_integrator.sv
// tb_ball_motion_integrator
//   Self-checking bench: a fixed-point behavioural model of the ball is
//   compared against the DUT at every falling clock edge, plus literal
//   checks for the directed scenarios and a randomized load/tick phase.
module tb_ball_motion_integrator;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   ball_motion_integrator_if bif ();

   ball_motion_integrator #(
      .FP_BITS(6), .FRICTION_PERIOD(4), .FRICTION_STEP(1),
      .MAX_SPEED(511), .INIT_X(200), .INIT_Y(200)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bif)
   );

   int total = 0;
   int bad = 0;
   int stop_cnt = 0;

   // Model state: velocity in 1/64 px/frame, position in 1/64 px.
   int  mvx = 0, mvy = 0, mpx = 200 * 64, mpy = 200 * 64, mcnt = 0;
   bit  mmoving = 0, mstop = 0;

   function automatic int wrap17(input int v);
      return ((v % 131072) + 131072 + 65536) % 131072 - 65536;
   endfunction

   function automatic int floor64(input int p);
      return (p >= 0) ? p / 64 : -((-p + 63) / 64);
   endfunction

   function automatic int satv(input int v);
      return (v > 511) ? 511 : (v < -511) ? -511 : v;
   endfunction

   function automatic int fric(input int v);
      return (v > 1) ? v - 1 : (v < -1) ? v + 1 : 0;
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mvx = 0; mvy = 0; mpx = 200 * 64; mpy = 200 * 64; mcnt = 0;
         mmoving = 0; mstop = 0;
      end else begin
         bit was;
         was = mmoving;
         if (bif.startOfFrame) begin
            mpx = wrap17(mpx + mvx);
            mpy = wrap17(mpy + mvy);
         end
         if (bif.velocityWriteEnable) begin
            mvx = satv(int'(bif.inVelocityX));
            mvy = satv(int'(bif.inVelocityY));
            mcnt = 0;
         end else if (bif.startOfFrame) begin
            mcnt = mcnt + 1;
            if (mcnt == 4) begin
               mcnt = 0;
               mvx = fric(mvx);
               mvy = fric(mvy);
            end
         end
         mmoving = (mvx != 0) || (mvy != 0);
         mstop = was && !mmoving;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Continuous compare against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (resetN) begin
         check("m_vx", int'(bif.outVelocityX), mvx);
         check("m_vy", int'(bif.outVelocityY), mvy);
         check("m_tlx", int'(bif.topLeftX), floor64(mpx));
         check("m_tly", int'(bif.topLeftY), floor64(mpy));
         check("m_moving", int'(bif.moving), int'(mmoving));
         check("m_stop", int'(bif.stopPulse), int'(mstop));
         if (bif.stopPulse) stop_cnt++;
      end
   end

   task automatic cyc(input bit s, input bit w, input int x, input int y);
      bif.startOfFrame        = s;
      bif.velocityWriteEnable = w;
      bif.inVelocityX         = 11'(x);
      bif.inVelocityY         = 11'(y);
      @(negedge clk);
   endtask

   task automatic tick();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      resetN = 1'b1;
      cyc(0, 0, 0, 0);
   endtask

   initial begin
      int base;
      bif.startOfFrame = 0; bif.velocityWriteEnable = 0;
      bif.inVelocityX = '0; bif.inVelocityY = '0;

      // 1: idle after reset
      do_reset();
      repeat (100) cyc(0, 0, 0, 0);
      check("t1_tlx", int'(bif.topLeftX), 200);
      check("t1_tly", int'(bif.topLeftY), 200);
      check("t1_vx", int'(bif.outVelocityX), 0);
      check("t1_moving", int'(bif.moving), 0);

      // 2: load then one tick
      cyc(0, 1, 64, -32);
      check("t2_vx", int'(bif.outVelocityX), 64);
      check("t2_vy", int'(bif.outVelocityY), -32);
      check("t2_moving", int'(bif.moving), 1);
      check("t2_tlx0", int'(bif.topLeftX), 200);
      tick();
      check("t2_tlx", int'(bif.topLeftX), 201);
      check("t2_tly", int'(bif.topLeftY), 199);

      // 3: friction to rest
      do_reset();
      stop_cnt = 0;
      cyc(0, 1, 2, 0);
      repeat (4) tick();
      check("t3_vx4", int'(bif.outVelocityX), 1);
      repeat (4) tick();
      check("t3_vx8", int'(bif.outVelocityX), 0);
      check("t3_moving", int'(bif.moving), 0);
      repeat (3) cyc(0, 0, 0, 0);
      check("t3_stopcnt", stop_cnt, 1);
      check("t3_tlx", int'(bif.topLeftX), 200);

      // 4: simultaneous load and tick
      do_reset();
      cyc(0, 1, 64, 0);
      base = int'(bif.topLeftX);
      cyc(1, 1, 10, 0);
      check("t4_tlx", int'(bif.topLeftX), base + 1);
      check("t4_vx", int'(bif.outVelocityX), 10);
      repeat (3) tick();
      check("t4_vx3", int'(bif.outVelocityX), 10);
      tick();
      check("t4_vx4", int'(bif.outVelocityX), 9);

      // 5: saturation and negative decay
      cyc(0, 1, 1000, -1024);
      check("t5_satx", int'(bif.outVelocityX), 511);
      check("t5_saty", int'(bif.outVelocityY), -511);
      cyc(0, 1, -5, 3);
      repeat (4) tick();
      check("t5_vx4", int'(bif.outVelocityX), -4);
      check("t5_vy4", int'(bif.outVelocityY), 2);
      repeat (16) tick();
      check("t5_vx20", int'(bif.outVelocityX), 0);
      check("t5_vy20", int'(bif.outVelocityY), 0);

      // 6: asynchronous reset mid-roll
      do_reset();
      stop_cnt = 0;
      cyc(0, 1, 300, 0);
      tick(); tick();
      #2 resetN = 1'b0;
      #1;
      check("t6_vx", int'(bif.outVelocityX), 0);
      check("t6_tlx", int'(bif.topLeftX), 200);
      check("t6_moving", int'(bif.moving), 0);
      check("t6_stop", int'(bif.stopPulse), 0);
      @(negedge clk);
      resetN = 1'b1;
      cyc(0, 1, 5, 5);
      check("t6_vx_after", int'(bif.outVelocityX), 5);
      check("t6_stopcnt", stop_cnt, 0);

      // Randomized loads and frame ticks
      repeat (3000) begin
         bit s, w;
         int x, y;
         s = ($urandom_range(0, 3) == 0);
         w = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            x = int'($urandom_range(0, 2047)) - 1024;
            y = int'($urandom_range(0, 2047)) - 1024;
         end else begin
            x = int'($urandom_range(0, 12)) - 6;
            y = int'($urandom_range(0, 12)) - 6;
         end
         cyc(s, w, x, y);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
